// File: rtl/complex_acc_stage.sv
// Complex dot-product accumulator: sums ACC_LEN signed complex products (or fewer on flush)
// and presents the widened sum over a valid/ready port.
module complex_acc_stage #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ACC_LEN    = 4,
   parameter int unsigned GUARD_BITS = 4
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic                                 sw_rst,
   input  logic                                 res_val,
   output logic                                 res_ready,
   input  logic [2*DATA_WIDTH-1:0]              result_re,
   input  logic [2*DATA_WIDTH-1:0]              result_im,
   input  logic                                 flush,
   output logic                                 acc_val,
   input  logic                                 acc_ready,
   output logic [2*DATA_WIDTH+GUARD_BITS-1:0]   acc_re,
   output logic [2*DATA_WIDTH+GUARD_BITS-1:0]   acc_im,
   output logic [$clog2(ACC_LEN+1)-1:0]         acc_n
);

   localparam int unsigned AW = 2*DATA_WIDTH + GUARD_BITS;
   localparam int unsigned NW = $clog2(ACC_LEN+1);

   typedef enum logic {StAccum, StOutput} state_e;

   state_e               r_state;
   state_e               w_state_next;
   logic signed [AW-1:0] r_sum_re;
   logic signed [AW-1:0] r_sum_im;
   logic signed [AW-1:0] w_term_re;
   logic signed [AW-1:0] w_term_im;
   logic signed [AW-1:0] w_add_re;
   logic signed [AW-1:0] w_add_im;
   logic [NW-1:0]        r_cnt;
   logic [NW-1:0]        w_cnt_inc;
   logic                 w_accept;
   logic                 w_emit;

   assign w_accept  = res_val && (r_state == StAccum);
   assign w_term_re = w_accept ? AW'($signed(result_re)) : '0;
   assign w_term_im = w_accept ? AW'($signed(result_im)) : '0;
   assign w_add_re  = r_sum_re + w_term_re;
   assign w_add_im  = r_sum_im + w_term_im;
   assign w_cnt_inc = r_cnt + NW'(w_accept);

   // Emit on a full group, or on flush when there is at least one term (held or arriving).
   assign w_emit = (r_state == StAccum) &&
                   ((w_accept && (r_cnt == NW'(ACC_LEN-1))) ||
                    (flush && ((r_cnt != '0) || w_accept)));

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StAccum:  if (w_emit)    w_state_next = StOutput;
         StOutput: if (acc_ready) w_state_next = StAccum;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= StAccum;
         r_sum_re <= '0;
         r_sum_im <= '0;
         r_cnt    <= '0;
         acc_re   <= '0;
         acc_im   <= '0;
         acc_n    <= '0;
      end else if (sw_rst) begin
         r_state  <= StAccum;
         r_sum_re <= '0;
         r_sum_im <= '0;
         r_cnt    <= '0;
         acc_re   <= '0;
         acc_im   <= '0;
         acc_n    <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_emit) begin
            acc_re   <= w_add_re;
            acc_im   <= w_add_im;
            acc_n    <= w_cnt_inc;
            r_sum_re <= '0;
            r_sum_im <= '0;
            r_cnt    <= '0;
         end else begin
            r_sum_re <= w_add_re;
            r_sum_im <= w_add_im;
            r_cnt    <= w_cnt_inc;
         end
      end
   end

   assign res_ready = (r_state == StAccum);
   assign acc_val   = (r_state == StOutput);

endmodule

// File: doc/complex_acc_stage.md
# complex_acc_stage

Downstream consumer of the complex-number multiplier. Accepts signed complex products over the multiplier's result handshake, sums `ACC_LEN` consecutive products (a complex dot product), and presents the widened sum on its own valid/ready output port. An early `flush` emits a partial sum. `sw_rst` is shared with the multiplier, so both stages clear together.

## Interface
- `DATA_WIDTH`, 8: multiplier operand width; input terms are `2*DATA_WIDTH` bits.
- `ACC_LEN`, 4: number of products per sum; must be 1 or more.
- `GUARD_BITS`, 4: extra accumulator MSBs; must satisfy `GUARD_BITS >= clog2(ACC_LEN)`.
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `sw_rst`  in  1  synchronous soft reset, active-high.
- `res_val`  in  1  product valid, from the multiplier.
- `res_ready`  out  1  product accept, to the multiplier.
- `result_re`  in  `2*DATA_WIDTH`  product real part, two's complement.
- `result_im`  in  `2*DATA_WIDTH`  product imaginary part, two's complement.
- `flush`  in  1  request early emission of a partial sum.
- `acc_val`  out  1  sum valid.
- `acc_ready`  in  1  sum accepted by the consumer.
- `acc_re`  out  `2*DATA_WIDTH+GUARD_BITS`  real sum, signed.
- `acc_im`  out  `2*DATA_WIDTH+GUARD_BITS`  imaginary sum, signed.
- `acc_n`  out  `clog2(ACC_LEN+1)`  number of terms in the presented sum.

## Operation
- The block has two states, ACCUM and OUTPUT. Both reset to ACCUM.
- `res_ready` is 1 exactly when the state is ACCUM.
- `acc_val` is 1 exactly when the state is OUTPUT.
- A term is accepted when `res_val` and `res_ready` are both 1 on a clock edge.
  - The accepted term is sign-extended to the accumulator width and added to the running sums (`sum_re`, `sum_im`).
  - The term counter `cnt` increments on each accepted term.
- Transition ACCUM to OUTPUT happens in either of these cases:
  - A term is accepted while `cnt == ACC_LEN-1`.
  - `flush` is 1 and either `cnt > 0` or a term is accepted in the same cycle.
- On that transition:
  - `acc_re` and `acc_im` load the sums, including the term accepted in that cycle.
  - `acc_n` loads the term count.
  - The internal sums and `cnt` clear to 0.
- `flush` with `cnt == 0` and no accepted term is ignored.
- `flush` while in OUTPUT is ignored.
- Transition OUTPUT to ACCUM happens on `acc_val && acc_ready`.
- While `acc_val` is 1, `acc_re`, `acc_im` and `acc_n` stay stable.
- Arithmetic wraps modulo `2^(2*DATA_WIDTH+GUARD_BITS)`. The `GUARD_BITS` constraint guarantees no overflow.
- `sw_rst` overrides every other event in the same cycle. It returns the block to ACCUM and clears the sums, `cnt`, `acc_re`, `acc_im`, `acc_n` and `acc_val`. Any accepted term or flush in that cycle is discarded.
- `rstn` low applies the same clear immediately, without waiting for a clock edge.

## Timing
- Reset values: `res_ready` = 1 once `rstn` is high. `acc_val`, `acc_re`, `acc_im` and `acc_n` are 0.
- Latency: if the last term is accepted on edge T, `acc_val` is 1 after edge T. The sum is visible in the cycle following T.
- Throughput: at most one term accepted per cycle. There is at least one dead input cycle per sum, because `res_ready` is 0 in OUTPUT.
- `res_ready` is a registered function of state only. It has no combinational path from `acc_ready` or `res_val`.
- `ACC_LEN = 1`: every accepted term moves to OUTPUT, one sum per term.
- Asserting `rstn` low mid-OUTPUT drops `acc_val` immediately. The pending sum is lost.

## Test plan
Configuration for all scenarios: `DATA_WIDTH` = 8, `ACC_LEN` = 4, `GUARD_BITS` = 4.
- Basic sum: terms (1,2), (3,-4), (100,0), (-5,5) on consecutive cycles -> `acc_val` rises one cycle after the 4th term, `acc_re` = 99, `acc_im` = 3, `acc_n` = 4, and `res_ready` = 0.
- Backpressure: after a sum is presented, hold `acc_ready` = 0 for 5 cycles -> `acc_val`, `acc_re`, `acc_im` and `acc_n` stay stable, `res_ready` stays 0. Raise `acc_ready` -> `res_ready` = 1 on the next cycle.
- Extremes: four terms of (0x7FFF, 0x8000) -> `acc_re` = 131068 (0x1FFFC), `acc_im` = -131072 (0xE0000 as 20 bits), no wrap.
- Flush cases, each must give the stated result:
  - Terms (10,-10) and (20,5), then `flush` -> `acc_re` = 30, `acc_im` = -5, `acc_n` = 2.
  - `flush` with `cnt` = 0 -> no `acc_val`.
  - `flush` in the same cycle as an accepted term (7,7) with `cnt` = 1 holding (1,1) -> `acc_re` = 8, `acc_im` = 8, `acc_n` = 2.
- Soft reset: 3 terms, then `sw_rst` for 1 cycle with `res_val` = 1, then four terms of (1,1) -> the sum is (4,4), `acc_n` = 4, and nothing from before the soft reset is included.
- Async reset: drive `rstn` low mid-OUTPUT, between clock edges -> `acc_val`, `acc_re` and `acc_im` go to 0 immediately. After release, `res_ready` = 1 and a new 4-term sum is correct.
